// File: rtl/dma_pingpong_pkg.sv
// rtl/dma_pingpong_pkg.sv - shared types and helpers for the DMA ping-pong reader and writer
package dma_pingpong_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    PRESENT = 2'd2
  } rd_state_e;

  // Bank of an instruction index is its MSB; msb is the index of that bit.
  function automatic logic bank_of(input logic [31:0] idx, input logic [4:0] msb);
    return idx[msb];
  endfunction

endpackage

// File: rtl/dma_pingpong_reader_if.sv
// rtl/dma_pingpong_reader_if.sv - instruction stream interface between reader and sequencer
interface dma_pingpong_reader_if #(
  parameter int TDATA_W = dma_pingpong_pkg::WORD_W * 4
);
  logic [TDATA_W-1:0] tdata;
  logic               tvalid;
  logic               tready;
  logic               tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/dma_pingpong_word_assembler.sv
// rtl/dma_pingpong_word_assembler.sv - gathers BRAM words into one wide instruction buffer
module dma_pingpong_word_assembler #(
  parameter int WORD_W = 32,
  parameter int WORDS  = 4,
  localparam int SLOT_W = (WORDS > 1) ? $clog2(WORDS) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic [SLOT_W-1:0]        in_slot,
  input  logic                     in_last,
  input  logic [WORD_W-1:0]        in_data,
  input  logic                     out_take,
  output logic                     out_valid,
  output logic [WORD_W*WORDS-1:0]  out_data
);
  logic [WORDS-1:0][WORD_W-1:0] words_q, words_d;
  logic                         full_q, full_d;

  // Merge the landing word so a completed instruction is visible the cycle its last word arrives.
  always_comb begin
    words_d = words_q;
    if (in_valid) words_d[in_slot] = in_data;
    out_valid = full_q | (in_valid & in_last);
    out_data  = words_d;
    full_d    = out_valid & ~out_take;
  end

  // Word storage and the "complete but not yet taken" flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      words_q <= '0;
      full_q  <= 1'b0;
    end else begin
      words_q <= words_d;
      full_q  <= full_d;
    end
  end
endmodule

// File: rtl/dma_pingpong_reader.sv
// rtl/dma_pingpong_reader.sv - ping-pong BRAM reader to AXI4-Stream; option DMA_PINGPONG_READER_UNDERRUN_EN
module dma_pingpong_reader
  import dma_pingpong_pkg::*;
#(
  parameter int ADDR_WIDTH           = 17,
  parameter int WORDS_IN_INSTRUCTION = 4,
  parameter int BRAM_WIDTH           = 32,
  parameter int READ_LATENCY         = 1,
  localparam int IDX_W = ADDR_WIDTH - $clog2(WORDS_IN_INSTRUCTION)
) (
  input  logic                     M_AXIS_ACLK,
  input  logic                     M_AXIS_ARESETN,
  input  logic                     start,
  input  logic [31:0]              num_instructions,
  output logic                     bram_en,
  output logic [ADDR_WIDTH-1:0]    bram_addr,
  input  logic [BRAM_WIDTH-1:0]    bram_dout,
  output logic                     bram_clk,
  output logic                     bram_rst,
  dma_pingpong_reader_if.master    m_axis,
  output logic [IDX_W-1:0]         instruction_monitor,
  output logic                     busy,
  output logic                     done
`ifdef DMA_PINGPONG_READER_UNDERRUN_EN
  ,
  input  logic [1:0]               bank_filled,
  output logic                     underrun
`endif
);
  localparam int W      = WORDS_IN_INSTRUCTION;
  localparam int RL     = READ_LATENCY;
  localparam int LOG_W  = $clog2(W);
  localparam int SLOT_W = (W > 1) ? LOG_W : 1;
  localparam int DW     = BRAM_WIDTH * W;
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(W - 1);

  rd_state_e                   state_q, state_d;
  logic                        busy_q, busy_d, done_q, done_d;
  logic [31:0]                 num_q, num_d, issued_q, issued_d, dlv_q, dlv_d;
  logic [1:0]                  outst_q, outst_d;
  logic                        fetch_act_q, fetch_act_d;
  logic [IDX_W-1:0]            fetch_idx_q, fetch_idx_d;
  logic [SLOT_W-1:0]           word_q, word_d;
  logic [RL-1:0]               rd_vld_q, rd_vld_d, rd_last_q, rd_last_d;
  logic [RL-1:0][SLOT_W-1:0]   rd_slot_q, rd_slot_d;
  logic [DW-1:0]               tdata_q, tdata_d;
  logic                        tvalid_q, tvalid_d, tlast_q, tlast_d;

  logic                        hs, last_hs, start_ok, boundary, bank_ok, begin_inst;
  logic [31:0]                 issued_eff;
  logic [1:0]                  outst_eff, outst_net;
  logic [IDX_W-1:0]            next_idx;
  logic                        asm_valid, asm_take;
  logic [DW-1:0]               asm_data;

`ifdef DMA_PINGPONG_READER_UNDERRUN_EN
  localparam int UR_LIMIT = 2 * W;
  localparam int UR_W     = $clog2(UR_LIMIT + 1);
  logic [UR_W-1:0]             ur_cnt_q, ur_cnt_d;
  logic                        underrun_q, underrun_d, ur_cond;
`endif

  dma_pingpong_word_assembler #(.WORD_W(BRAM_WIDTH), .WORDS(W)) u_asm (
    .clk      (M_AXIS_ACLK),
    .rst_n    (M_AXIS_ARESETN),
    .in_valid (rd_vld_q[RL-1]),
    .in_slot  (rd_slot_q[RL-1]),
    .in_last  (rd_last_q[RL-1]),
    .in_data  (bram_dout),
    .out_take (asm_take),
    .out_valid(asm_valid),
    .out_data (asm_data)
  );

  // Next-state: start acceptance, fetch issue with two-deep credit, read pipeline, output register.
  always_comb begin
    hs         = tvalid_q & m_axis.tready;
    last_hs    = hs & tlast_q;
    start_ok   = (state_q == IDLE) & start & (num_instructions != 32'd0);
    num_d      = start_ok ? num_instructions : num_q;
    issued_eff = start_ok ? 32'd0 : issued_q;
    outst_eff  = start_ok ? 2'd0 : outst_q;
    outst_net  = outst_eff - {1'b0, hs};
    next_idx   = (issued_eff == 32'd0) ? '0 : fetch_idx_q + IDX_W'(1);
    bank_ok    = 1'b1;
`ifdef DMA_PINGPONG_READER_UNDERRUN_EN
    if (next_idx[IDX_W-2:0] == '0)
      bank_ok = bank_filled[bank_of(32'(next_idx), 5'(IDX_W - 1))];
`endif
    // A new instruction may start only between instructions and while an output slot is free.
    boundary   = ~fetch_act_q | (word_q == LAST_SLOT);
    begin_inst = (busy_q | start_ok) & boundary & (issued_eff < num_d) &
                 (outst_net < 2'd2) & bank_ok;

    fetch_act_d = fetch_act_q;
    word_d      = word_q;
    fetch_idx_d = fetch_idx_q;
    issued_d    = issued_eff;
    if (fetch_act_q) begin
      if (word_q == LAST_SLOT) fetch_act_d = 1'b0;
      else                     word_d      = word_q + SLOT_W'(1);
    end
    if (begin_inst) begin
      fetch_act_d = 1'b1;
      word_d      = '0;
      fetch_idx_d = next_idx;
      issued_d    = issued_eff + 32'd1;
    end
    outst_d = outst_net + {1'b0, begin_inst};

    rd_vld_d  = RL'({rd_vld_q, fetch_act_q});
    rd_last_d = RL'({rd_last_q, (word_q == LAST_SLOT)});
    rd_slot_d = (RL * SLOT_W)'({rd_slot_q, word_q});

    asm_take = asm_valid & (~tvalid_q | hs);
    tvalid_d = tvalid_q & ~hs;
    tdata_d  = tdata_q;
    tlast_d  = tlast_q;
    if (asm_take) begin
      tvalid_d = 1'b1;
      tdata_d  = asm_data;
      tlast_d  = ((dlv_q + 32'(hs)) == (num_q - 32'd1));
    end
    dlv_d = start_ok ? 32'd0 : dlv_q + 32'(hs);

    busy_d = busy_q;
    if (start_ok) busy_d = 1'b1;
    if (last_hs)  busy_d = 1'b0;
    done_d = last_hs;

    if (!busy_d)       state_d = IDLE;
    else if (tvalid_d) state_d = PRESENT;
    else               state_d = FETCH;

`ifdef DMA_PINGPONG_READER_UNDERRUN_EN
    ur_cond  = busy_q & m_axis.tready & ~tvalid_q;
    ur_cnt_d = '0;
    if (ur_cond)
      ur_cnt_d = (ur_cnt_q == UR_W'(UR_LIMIT)) ? ur_cnt_q : ur_cnt_q + UR_W'(1);
    underrun_d = start_ok ? 1'b0 :
                 (underrun_q | (ur_cond & (ur_cnt_q == UR_W'(UR_LIMIT))));
`endif
  end

  // State register; reset drops every in-flight read and returns all outputs to idle values.
  always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
    if (!M_AXIS_ARESETN) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      num_q       <= '0;
      issued_q    <= '0;
      dlv_q       <= '0;
      outst_q     <= '0;
      fetch_act_q <= 1'b0;
      fetch_idx_q <= '0;
      word_q      <= '0;
      rd_vld_q    <= '0;
      rd_last_q   <= '0;
      rd_slot_q   <= '0;
      tdata_q     <= '0;
      tvalid_q    <= 1'b0;
      tlast_q     <= 1'b0;
`ifdef DMA_PINGPONG_READER_UNDERRUN_EN
      ur_cnt_q    <= '0;
      underrun_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      num_q       <= num_d;
      issued_q    <= issued_d;
      dlv_q       <= dlv_d;
      outst_q     <= outst_d;
      fetch_act_q <= fetch_act_d;
      fetch_idx_q <= fetch_idx_d;
      word_q      <= word_d;
      rd_vld_q    <= rd_vld_d;
      rd_last_q   <= rd_last_d;
      rd_slot_q   <= rd_slot_d;
      tdata_q     <= tdata_d;
      tvalid_q    <= tvalid_d;
      tlast_q     <= tlast_d;
`ifdef DMA_PINGPONG_READER_UNDERRUN_EN
      ur_cnt_q    <= ur_cnt_d;
      underrun_q  <= underrun_d;
`endif
    end
  end

  assign bram_en             = fetch_act_q;
  assign bram_addr           = (ADDR_WIDTH'(fetch_idx_q) << LOG_W) | ADDR_WIDTH'(word_q);
  assign bram_clk            = M_AXIS_ACLK;
  assign bram_rst            = ~M_AXIS_ARESETN;
  assign m_axis.tdata        = tdata_q;
  assign m_axis.tvalid       = tvalid_q;
  assign m_axis.tlast        = tlast_q;
  assign instruction_monitor = fetch_idx_q;
  assign busy                = busy_q;
  assign done                = done_q;
`ifdef DMA_PINGPONG_READER_UNDERRUN_EN
  assign underrun            = underrun_q;
`endif
endmodule
